// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer: one 128-bit state register is walked
// through InitialRound, NR-1 full rounds and a FinalRound, one per cycle.
// Round keys are fetched combinationally from an external store via rk_idx.
// NR must be 10, 12 or 14.
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic         abort,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    localparam logic [3:0] LAST_FULL = 4'(NR - 1);
    localparam logic [3:0] FINAL_IDX = 4'(NR);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_t         fsm, fsm_next;
    logic [3:0]   cnt, cnt_next;
    logic [127:0] blk, blk_next;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes fused with ShiftRows. Byte i of the block is row i%4, column i/4;
    // row r is rotated left by r columns.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] full_round(input logic [127:0] s, input logic [127:0] k);
        return mix_columns(sub_shift(s)) ^ k;
    endfunction

    function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] k);
        return sub_shift(s) ^ k;
    endfunction

    // FSM, round counter and block state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
            cnt <= 4'd0;
            blk <= '0;
        end else begin
            fsm <= fsm_next;
            cnt <= cnt_next;
            blk <= blk_next;
        end
    end

    // Next-state, round datapath select and handshake outputs.
    always_comb begin
        fsm_next  = fsm;
        cnt_next  = cnt;
        blk_next  = blk;
        in_ready  = 1'b0;
        rk_idx    = 4'd0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                // abort wins over a new block; nothing is accepted while rst is held
                in_ready = !abort && !rst;
                if (in_valid && in_ready) begin
                    blk_next = in_data ^ rk_data;
                    cnt_next = 4'd1;
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                busy   = 1'b1;
                rk_idx = cnt;
                if (abort) begin
                    fsm_next = IDLE;
                    cnt_next = 4'd0;
                end else begin
                    blk_next = full_round(blk, rk_data);
                    cnt_next = cnt + 4'd1;
                    if (cnt == LAST_FULL) begin
                        fsm_next = FINAL;
                    end
                end
            end
            FINAL: begin
                busy   = 1'b1;
                rk_idx = FINAL_IDX;
                if (abort) begin
                    fsm_next = IDLE;
                    cnt_next = 4'd0;
                end else begin
                    blk_next = final_round(blk, rk_data);
                    fsm_next = DONE;
                end
            end
            DONE: begin
                // rk_idx stays 0 so the next block's rk0 is already selected
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    fsm_next = IDLE;
                    cnt_next = 4'd0;
                end
            end
            default: begin
                fsm_next = IDLE;
                cnt_next = 4'd0;
            end
        endcase
    end

    assign out_data = blk;

endmodule
